packet_gen: RTL

PACKET_GEN -- requirements
Module: packet_gen

---
 rtl/packet_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/packet_gen.sv
// packet_gen: emits 8-word segmented test packets with LFSR or fixed length/destination.
// Define PACKET_GEN_STATS_EN to build saturating packet and segment counters.
module packet_gen #(
  parameter logic [47:0] MAC_BASE = 48'h0200_0000_0000,
  parameter int unsigned GAP_SEGS = 1,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gen_en,
  input  logic        cfg_fixed,
  input  logic [5:0]  cfg_len_blocks,
  input  logic [1:0]  cfg_dst,
  output logic [31:0] packet_out,
  output logic        packet_en,
  output logic        busy,
  output logic [15:0] pkt_count,
  output logic [15:0] seg_count
);
  localparam logic [15:0] SEED_INIT = (SEED == 16'h0) ? 16'hACE1 : SEED;
  localparam logic [3:0]  GAP_LAST  = 4'(GAP_SEGS - 1);
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  state_t      state_q, state_d;
  logic [2:0]  slot_q, slot_d;
  logic [5:0]  seg_q, seg_d, blocks_q, blocks_d, raw_blocks;
  logic [1:0]  dst_q, dst_d;
  logic [3:0]  gap_q, gap_d;
  logic [15:0] lfsr_q, lfsr_d, seq_q, seq_d, len_bytes;
  logic [47:0] dmac;
  logic [31:0] packet_out_q, packet_out_d;
  logic        packet_en_q, packet_en_d, busy_q, busy_d;
  logic        last_word, latch_ok, relatch;
  always_comb begin
    slot_d     = slot_q + 3'd1;
    last_word  = state_q == SEND && slot_q == 3'd7 && seg_q == blocks_q - 6'd1;
    latch_ok   = slot_q == 3'd7 && (state_q == IDLE || (state_q == GAP && gap_q == GAP_LAST) ||
                 (last_word && GAP_SEGS == 0));
    relatch    = latch_ok && gen_en;
    raw_blocks = cfg_fixed ? cfg_len_blocks : lfsr_q[5:0];
    state_d    = state_q;
    seg_d      = seg_q;
    gap_d      = gap_q;
    blocks_d   = blocks_q;
    dst_d      = dst_q;
    lfsr_d     = lfsr_q;
    seq_d      = last_word ? seq_q + 16'd1 : seq_q;
    if (relatch) begin
      state_d  = SEND;
      seg_d    = 6'd0;
      blocks_d = raw_blocks < 6'd2 ? 6'd2 : raw_blocks > 6'd47 ? 6'd47 : raw_blocks;
      dst_d    = cfg_fixed ? cfg_dst : lfsr_q[7:6];
      lfsr_d   = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end else if (latch_ok) begin
      state_d = IDLE;
    end else if (last_word) begin
      state_d = GAP;
      gap_d   = 4'd0;
    end else if (slot_q == 3'd7 && state_q == SEND) begin
      seg_d = seg_q + 6'd1;
    end else if (slot_q == 3'd7 && state_q == GAP) begin
      gap_d = gap_q + 4'd1;
    end
    // outputs are built from the next state so they register in step with it
    dmac         = {MAC_BASE[47:2], dst_d};
    len_bytes    = {5'd0, blocks_d, 5'd0};
    packet_out_d = state_d != SEND ? 32'd0 :
                   seg_d == 6'd0 && slot_d == 3'd0 ? {len_bytes, dmac[47:32]} :
                   seg_d == 6'd0 && slot_d == 3'd1 ? dmac[31:0] :
                   seg_d == 6'd0 && slot_d == 3'd2 ? {16'hA5A5, seq_d} :
                   {seq_d, 2'b00, seg_d, 5'd0, slot_d};
    packet_en_d  = state_d == SEND && slot_d == 3'd0;
    busy_d       = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slot_q       <= 3'd0;
      seg_q        <= 6'd0;
      gap_q        <= 4'd0;
      blocks_q     <= 6'd2;
      dst_q        <= 2'd0;
      lfsr_q       <= SEED_INIT;
      seq_q        <= 16'd0;
      packet_out_q <= 32'd0;
      packet_en_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      seg_q        <= seg_d;
      gap_q        <= gap_d;
      blocks_q     <= blocks_d;
      dst_q        <= dst_d;
      lfsr_q       <= lfsr_d;
      seq_q        <= seq_d;
      packet_out_q <= packet_out_d;
      packet_en_q  <= packet_en_d;
      busy_q       <= busy_d;
    end
  end
  assign packet_out = packet_out_q;
  assign packet_en  = packet_en_q;
  assign busy       = busy_q;
`ifdef PACKET_GEN_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d, seg_count_q, seg_count_d;
  always_comb begin
    pkt_count_d = pkt_count_q + {15'd0, last_word && pkt_count_q != 16'hFFFF};
    seg_count_d = seg_count_q + {15'd0, packet_en_q && seg_count_q != 16'hFFFF};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_count_q <= 16'd0;
      seg_count_q <= 16'd0;
    end else begin
      pkt_count_q <= pkt_count_d;
      seg_count_q <= seg_count_d;
    end
  end
  assign pkt_count = pkt_count_q;
  assign seg_count = seg_count_q;
`else
  assign pkt_count = 16'd0;
  assign seg_count = 16'd0;
`endif
endmodule
